// File: rtl/icache_ctrl.sv
// icache_ctrl -- direct-mapped, one-word-per-block instruction cache.
// Sits between fetch and the memory arbiter. A lookup is combinational, so a hit
// returns its word in the same cycle. A miss holds iREN until memory drops iwait,
// fills the frame, and returns to IDLE, where the fetch address is looked up again.
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   imemREN, imemaddr  fetch read request and byte address
//   flush              invalidate every frame and abandon any outstanding miss
//   ihit, imemload     hit strobe and instruction word (word is 0 when there is no hit)
//   iREN, iaddr        memory read request and word address, held for the whole miss
//   iwait, iload       memory busy flag and read data (iload is valid when iwait is 0)
//   hit_cnt, miss_cnt  wrapping statistics counters
module icache_ctrl #(
  parameter int WORD_W = 32,
  parameter int ITAG_W = 26,
  parameter int IIDX_W = 4,
  parameter int IBYT_W = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  input  logic              flush,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] hit_cnt,
  output logic [WORD_W-1:0] miss_cnt
);
  localparam int NFRM = 1 << IIDX_W;

  typedef enum logic {IDLE, MISS} state_e;

  state_e            state_q, state_d;
  logic [NFRM-1:0]   valid_q, valid_d;
  logic [ITAG_W-1:0] tag_q  [NFRM];
  logic [WORD_W-1:0] data_q [NFRM];
  logic [WORD_W-1:0] miss_addr_q, miss_addr_d;
  logic [WORD_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [WORD_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [IIDX_W-1:0] lk_idx, fill_idx;
  logic [ITAG_W-1:0] lk_tag;
  logic              lookup_hit, fill_we;

  assign lk_idx   = imemaddr[IBYT_W +: IIDX_W];
  assign lk_tag   = imemaddr[WORD_W-1 -: ITAG_W];
  assign fill_idx = miss_addr_q[IBYT_W +: IIDX_W];

  // Tag match only counts in IDLE; during a miss the fetch address may already be redirected.
  assign lookup_hit = (state_q == IDLE) && imemREN && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    miss_addr_d = miss_addr_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    fill_we     = 1'b0;
    ihit        = 1'b0;
    imemload    = '0;
    iREN        = 1'b0;
    iaddr       = '0;
    case (state_q)
      IDLE: begin
        if (lookup_hit && !flush) begin
          ihit      = 1'b1;
          imemload  = data_q[lk_idx];
          hit_cnt_d = hit_cnt_q + WORD_W'(1);
        end else if (imemREN && !lookup_hit && !flush) begin
          state_d     = MISS;
          miss_addr_d = {imemaddr[WORD_W-1:IBYT_W], {IBYT_W{1'b0}}};
          miss_cnt_d  = miss_cnt_q + WORD_W'(1);
        end
      end
      MISS: begin
        iREN  = 1'b1;
        iaddr = miss_addr_q;
        if (!iwait) begin
          state_d = IDLE;
          // A flush on the completing cycle discards the returned word.
          if (!flush) begin
            fill_we           = 1'b1;
            valid_d[fill_idx] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      valid_d = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      miss_addr_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      miss_addr_q <= miss_addr_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Tag/data store is never reset; the valid bits alone gate its use.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= miss_addr_q[WORD_W-1 -: ITAG_W];
      data_q[fill_idx] <= iload;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl -- directed cases for the cache corner behaviours, then a randomized
// phase where a reference cache model predicts hits, misses and returned words; the
// predictions go into queues and a monitor compares them against what the DUT presents.
module tb_icache_ctrl;
  logic        CLK, RST, imemREN, flush, ihit, iREN, iwait;
  logic [31:0] imemaddr, imemload, iaddr, iload, hit_cnt, miss_cnt;

  icache_ctrl dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .flush(flush),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr), .iwait(iwait),
    .iload(iload), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int exp_hits = 0;
  int exp_miss = 0;

  // Reference cache: 16 frames, plain arrays indexed by address bits [5:2].
  bit          mvalid [16];
  logic [25:0] mtag   [16];
  logic [31:0] mdata  [16];

  logic [31:0] hitq  [$];
  logic [31:0] missq [$];
  bit          mon_en   = 0;
  bit          auto_mem = 0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Memory responder for the random phase: random wait states, then the word for iaddr.
  int wcnt = 0;
  always @(negedge CLK) begin
    if (auto_mem) begin
      if (iREN) begin
        if (wcnt > 0) begin
          iwait = 1'b1;
          wcnt--;
        end else begin
          iwait = 1'b0;
          iload = memword(iaddr);
          wcnt  = $urandom_range(0, 3);
        end
      end else begin
        iwait = 1'b1;
      end
    end
  end

  // Monitor: pops an expected word per hit and an expected address per new miss.
  bit          iren_prev = 0;
  logic [31:0] cur_iaddr = '0;
  always @(negedge CLK) begin
    if (mon_en) begin
      if (ihit) begin
        if (hitq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_hit actual addr=%h expected none", imemaddr);
        end else begin
          chk("sb_hit_data", imemload, hitq.pop_front());
        end
      end
      if (iREN) begin
        chk("sb_ihit_in_miss", {31'b0, ihit}, 32'h0);
        if (!iren_prev) begin
          if (missq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_miss actual iaddr=%h expected none", iaddr);
          end else begin
            chk("sb_miss_addr", iaddr, missq.pop_front());
          end
          cur_iaddr = iaddr;
        end else begin
          chk("sb_iaddr_stable", iaddr, cur_iaddr);
        end
      end
    end
    iren_prev = iREN;
  end

  // Directed helpers; all start just after a rising edge.
  task automatic miss_fill(input logic [31:0] a, input logic [31:0] d, input int nwait);
    imemaddr = a; imemREN = 1'b1; iwait = 1'b1;
    exp_miss++;
    @(negedge CLK); chk("miss_nohit", {31'b0, ihit}, 32'h0);
    @(posedge CLK);
    repeat (nwait) begin
      @(negedge CLK);
      chk("wait_iren", {31'b0, iREN}, 32'h1);
      chk("wait_iaddr", iaddr, {a[31:2], 2'b00});
      chk("wait_nohit", {31'b0, ihit}, 32'h0);
    end
    @(negedge CLK);
    chk("miss_iren", {31'b0, iREN}, 32'h1);
    chk("miss_iaddr", iaddr, {a[31:2], 2'b00});
    iwait = 1'b0; iload = d;
    @(posedge CLK); #1 iwait = 1'b1;
  endtask

  task automatic expect_hit(input logic [31:0] d);
    @(negedge CLK);
    chk("hit_flag", {31'b0, ihit}, 32'h1);
    chk("hit_data", imemload, d);
    chk("hit_noiren", {31'b0, iREN}, 32'h0);
    exp_hits++;
    @(posedge CLK); #1 imemREN = 1'b0;
  endtask

  // Random-phase fetch: the model decides hit or miss from its own frame contents.
  task automatic fetch(input logic [31:0] a);
    int  idx;
    bit  seen;
    idx  = int'(a[5:2]);
    imemaddr = a; imemREN = 1'b1;
    if (!(mvalid[idx] && mtag[idx] == a[31:6])) begin
      missq.push_back({a[31:2], 2'b00});
      exp_miss++;
      mvalid[idx] = 1'b1;
      mtag[idx]   = a[31:6];
      mdata[idx]  = memword({a[31:2], 2'b00});
    end
    hitq.push_back(mdata[idx]);
    exp_hits++;
    seen = 0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge CLK);
      if (ihit) seen = 1;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL fetch_timeout actual no hit expected hit addr=%h", a);
    end
    @(posedge CLK); #1 imemREN = 1'b0;
  endtask

  initial begin
    RST = 1'b1; imemREN = 1'b0; imemaddr = '0; flush = 1'b0; iwait = 1'b1; iload = '0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_ihit", {31'b0, ihit}, 32'h0);
    chk("rst_imemload", imemload, 32'h0);
    chk("rst_iren", {31'b0, iREN}, 32'h0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_hitcnt", hit_cnt, 32'h0);
    chk("rst_misscnt", miss_cnt, 32'h0);
    @(posedge CLK); #1;

    // Cold miss then re-lookup hit.
    miss_fill(32'h0000_0040, 32'h2000_0001, 0);
    expect_hit(32'h2000_0001);
    @(negedge CLK);
    chk("cold_misscnt", miss_cnt, 32'd1);
    chk("cold_hitcnt", hit_cnt, 32'd1);
    @(posedge CLK); #1;

    // Five wait-state cycles.
    miss_fill(32'h0000_0044, 32'h1111_2222, 5);
    expect_hit(32'h1111_2222);

    // Conflict on idx0: replacing the frame forces the original to miss again.
    miss_fill(32'h0000_0000, 32'hAAAA_0000, 1);
    expect_hit(32'hAAAA_0000);
    miss_fill(32'h0000_0040, 32'hBBBB_0040, 0);
    expect_hit(32'hBBBB_0040);
    miss_fill(32'h0000_0000, 32'hAAAA_0000, 2);
    expect_hit(32'hAAAA_0000);

    // Fill idx0..3, flush, every one misses again.
    for (int i = 1; i < 4; i++) begin
      miss_fill(32'(i * 4), 32'hC000_0000 + 32'(i), 0);
      expect_hit(32'hC000_0000 + 32'(i));
    end
    flush = 1'b1;
    @(posedge CLK); #1 flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      miss_fill(32'(i * 4), 32'hD000_0000 + 32'(i), 0);
      expect_hit(32'hD000_0000 + 32'(i));
    end

    // Flush on the fill-complete cycle drops the fill.
    imemaddr = 32'h10; imemREN = 1'b1; iwait = 1'b1; exp_miss++;
    @(posedge CLK);
    @(negedge CLK);
    chk("ff_iren", {31'b0, iREN}, 32'h1);
    iwait = 1'b0; iload = 32'hF0F0_0001; flush = 1'b1;
    @(posedge CLK); #1 iwait = 1'b1; flush = 1'b0;
    @(negedge CLK);
    chk("ff_iren_drop", {31'b0, iREN}, 32'h0);
    chk("ff_frame_invalid", {31'b0, ihit}, 32'h0);
    exp_miss++;
    @(posedge CLK);
    @(negedge CLK);
    chk("ff_remiss_iaddr", iaddr, 32'h10);
    iwait = 1'b0; iload = 32'hF0F0_0002;
    @(posedge CLK); #1 iwait = 1'b1;
    expect_hit(32'hF0F0_0002);

    // Flush on a would-be hit: no hit, no count.
    imemaddr = 32'h10; imemREN = 1'b1; flush = 1'b1;
    @(negedge CLK);
    chk("flush_hit_suppressed", {31'b0, ihit}, 32'h0);
    @(posedge CLK); #1 flush = 1'b0; imemREN = 1'b0;
    miss_fill(32'h10, 32'hF0F0_0003, 0);
    expect_hit(32'hF0F0_0003);

    // Redirect during a miss: the original fill completes, the new address then misses.
    imemaddr = 32'h80; imemREN = 1'b1; iwait = 1'b1; exp_miss++;
    @(posedge CLK);
    @(negedge CLK);
    chk("redir_iaddr0", iaddr, 32'h80);
    imemaddr = 32'h84;
    @(negedge CLK);
    chk("redir_iaddr1", iaddr, 32'h80);
    iwait = 1'b0; iload = 32'h8080_8080;
    @(posedge CLK); #1 iwait = 1'b1; exp_miss++;
    @(negedge CLK);
    chk("redir_new_nohit", {31'b0, ihit}, 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    chk("redir_new_iaddr", iaddr, 32'h84);
    iwait = 1'b0; iload = 32'h8484_8484;
    @(posedge CLK); #1 iwait = 1'b1;
    expect_hit(32'h8484_8484);
    imemaddr = 32'h83; imemREN = 1'b1;
    expect_hit(32'h8080_8080);
    @(negedge CLK);
    chk("dir_hitcnt", hit_cnt, 32'(exp_hits));
    chk("dir_misscnt", miss_cnt, 32'(exp_miss));
    @(posedge CLK); #1;

    // Reset during a miss.
    imemaddr = 32'h100; imemREN = 1'b1; iwait = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("rmid_iren", {31'b0, iREN}, 32'h1);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("rmid_iren_drop", {31'b0, iREN}, 32'h0);
    chk("rmid_hitcnt", hit_cnt, 32'h0);
    chk("rmid_misscnt", miss_cnt, 32'h0);
    @(posedge CLK); #1 RST = 1'b0;
    exp_hits = 0; exp_miss = 0;
    miss_fill(32'h100, 32'h0100_0100, 0);
    expect_hit(32'h0100_0100);
    miss_fill(32'h80, 32'h0080_0080, 0);
    expect_hit(32'h0080_0080);

    // Random phase against the reference model.
    flush = 1'b1;
    @(posedge CLK); #1 flush = 1'b0;
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    auto_mem = 1;
    mon_en   = 1;
    for (int t = 0; t < 300; t++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        flush = 1'b1;
        @(posedge CLK); #1 flush = 1'b0;
        for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
      end else if (r == 1) begin
        imemaddr = $urandom;
        @(posedge CLK); #1;
      end else begin
        fetch($urandom & 32'hC000_00FF);
      end
    end
    mon_en = 0;
    @(negedge CLK);
    chk("end_hitcnt", hit_cnt, 32'(exp_hits));
    chk("end_misscnt", miss_cnt, 32'(exp_miss));
    chk("end_hitq_empty", 32'(hitq.size()), 32'h0);
    chk("end_missq_empty", 32'(missq.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual running expected finished");
    $fatal(1, "timeout");
  end
endmodule
